// File: rtl/adder_pkg.sv
// Shared constants and helpers for the segmented pipelined adder.
// Default geometry, stage count and configuration legality check.
package adder_pkg;

    localparam int ADDER_WIDTH = 9;
    localparam int ADDER_SEG   = 3;

    // One pipeline stage per carry segment.
    function automatic int num_stages(input int width, input int seg);
        return width / seg;
    endfunction

    // Legal geometry: at least 2 bits and whole segments only.
    function automatic bit seg_cfg_ok(input int width, input int seg);
        return (seg > 0) && (width >= 2) && ((width % seg) == 0);
    endfunction

endpackage

// File: rtl/adder_seg.sv
// Combinational SEG-bit add slice with carry in and carry out.
// Instantiated once per pipeline stage.
module adder_seg
    import adder_pkg::*;
#(
    parameter int SEG = ADDER_SEG
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] s,
    output logic           cout
);

    // Carry chain limited to SEG bits.
    assign {cout, s} = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, cin};

endmodule

// File: rtl/adder_pipe_seg.sv
// Pipelined add/subtract, SEG bits of carry resolved per stage.
// Global stall on output backpressure; carry, skew and deskew in regs.
module adder_pipe_seg
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH,
    parameter int SEG   = ADDER_SEG
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = num_stages(WIDTH, SEG);
    localparam logic [WIDTH-1:0] SEG_MASK = WIDTH'({SEG{1'b1}});

    if (!seg_cfg_ok(WIDTH, SEG)) begin : g_bad_cfg
        $error("adder_pipe_seg: WIDTH must be >= 2 and a multiple of SEG");
    end

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             c0;

    // Stage registers: valid, carry, operand skew, result deskew.
    logic [STAGES-1:0]            v_q;
    logic [STAGES-1:0]            c_q;
    logic [STAGES-1:0][WIDTH-1:0] a_q;
    logic [STAGES-1:0][WIDTH-1:0] b_q;
    logic [STAGES-1:0][WIDTH-1:0] s_q;

    // Per-stage inputs (from capture or previous stage) and results.
    logic [STAGES-1:0]            pv;
    logic [STAGES-1:0]            pc;
    logic [STAGES-1:0][WIDTH-1:0] pa;
    logic [STAGES-1:0][WIDTH-1:0] pb;
    logic [STAGES-1:0][WIDTH-1:0] ps;
    logic [STAGES-1:0][SEG-1:0]   sum;
    logic [STAGES-1:0]            co;
    logic [STAGES-1:0][WIDTH-1:0] s_nxt;

    // Subtract is a + ~b + ~cin; cout then means "no borrow".
    assign b_eff = sub ? ~b : b;
    assign c0    = sub ? ~cin : cin;

    // Whole pipe moves unless a result is waiting on the consumer.
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage

        if (k == 0) begin : g_head
            assign pv[k] = in_valid;
            assign pc[k] = c0;
            assign pa[k] = a;
            assign pb[k] = b_eff;
            assign ps[k] = '0;
        end else begin : g_body
            assign pv[k] = v_q[k-1];
            assign pc[k] = c_q[k-1];
            assign pa[k] = a_q[k-1];
            assign pb[k] = b_q[k-1];
            assign ps[k] = s_q[k-1];
        end

        adder_seg #(
            .SEG (SEG)
        ) u_seg (
            .a    (pa[k][k*SEG +: SEG]),
            .b    (pb[k][k*SEG +: SEG]),
            .cin  (pc[k]),
            .s    (sum[k]),
            .cout (co[k])
        );

        // Drop this stage's segment into the deskewed result.
        assign s_nxt[k] = (ps[k] & ~(SEG_MASK << (k * SEG)))
                        | (WIDTH'(sum[k]) << (k * SEG));
    end

    // All stages load together on advance, hold together on stall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_q <= '0;
            c_q <= '0;
            a_q <= '0;
            b_q <= '0;
            s_q <= '0;
        end else if (adv) begin
            v_q <= pv;
            c_q <= co;
            a_q <= pa;
            b_q <= pb;
            s_q <= s_nxt;
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign s         = s_q[STAGES-1];
    assign cout      = c_q[STAGES-1];

    // Same-sign operands producing an opposite-sign result.
    assign ovf = (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1])
              && (s_q[STAGES-1][WIDTH-1] != a_q[STAGES-1][WIDTH-1]);

endmodule

// File: tb/tb_adder_pipe_seg.sv
// Self-checking bench: four geometries driven from one stimulus,
// each scored against an arithmetic model with latency tracking.
module tb_adder_pipe_seg;

    localparam int ND = 4;
    localparam int WD [ND] = '{9, 8, 16, 9};
    localparam int SG [ND] = '{3, 1, 4, 9};

    typedef struct packed {
        logic        o;
        logic        c;
        logic [15:0] s;
    } res_t;

    typedef struct {
        res_t r;
        int   n;
        int   stl;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic        cin_in;
    logic        sub_in;
    logic [15:0] a_in;
    logic [15:0] b_in;

    logic [15:0] s_w  [ND];
    logic        ov_w [ND];
    logic        ir_w [ND];
    logic        co_w [ND];
    logic        of_w [ND];

    int   checks = 0;
    int   errors = 0;
    bit   done   = 0;
    exp_t q [ND][$];

    always #5 clk = ~clk;

    for (genvar i = 0; i < ND; i++) begin : g_dut
        localparam int W = WD[i];
        logic [W-1:0] s_i;
        logic         ov_i;
        logic         ir_i;
        logic         co_i;
        logic         of_i;

        adder_pipe_seg #(
            .WIDTH (W),
            .SEG   (SG[i])
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (ir_i),
            .a         (a_in[W-1:0]),
            .b         (b_in[W-1:0]),
            .cin       (cin_in),
            .sub       (sub_in),
            .out_valid (ov_i),
            .out_ready (out_ready),
            .s         (s_i),
            .cout      (co_i),
            .ovf       (of_i)
        );

        assign s_w[i]  = 16'(s_i);
        assign ov_w[i] = ov_i;
        assign ir_w[i] = ir_i;
        assign co_w[i] = co_i;
        assign of_w[i] = of_i;
    end

    // Plain integer arithmetic: unsigned result, borrow, signed range.
    function automatic res_t model(input int w, input logic [15:0] av,
                                   input logic [15:0] bv,
                                   input logic ci, input logic sb);
        longint m, ua, ub, sa, sbv, ur, r;
        res_t   x;
        m   = longint'(1) << w;
        ua  = longint'(av) & (m - 1);
        ub  = longint'(bv) & (m - 1);
        sa  = (ua >= m / 2) ? ua - m : ua;
        sbv = (ub >= m / 2) ? ub - m : ub;
        if (!sb) begin
            ur  = ua + ub + longint'(ci);
            r   = sa + sbv + longint'(ci);
            x.c = (ur >= m);
        end else begin
            ur  = ua - ub - longint'(ci);
            r   = sa - sbv - longint'(ci);
            x.c = (ua >= ub + longint'(ci));
        end
        x.s = 16'(((ur % m) + m) % m);
        x.o = (r >= m / 2) || (r < -(m / 2));
        return x;
    endfunction

    task automatic chk(input int i, input string nm, input int act,
                       input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL dut%0d %s: got %0d want %0d", i, nm, act, exp);
        end
    endtask

    task automatic pin(input string nm, input res_t got, input logic o,
                       input logic c, input int sv);
        chk(-1, {nm, ".s"}, int'(got.s), sv);
        chk(-1, {nm, ".c"}, int'(got.c), int'(c));
        chk(-1, {nm, ".o"}, int'(got.o), int'(o));
    endtask

    function automatic int pending();
        int t = 0;
        for (int i = 0; i < ND; i++) t += q[i].size();
        return t;
    endfunction

    // Per-cycle scoreboard, sampled on the falling edge.
    task automatic monitor();
        int          n = 0;
        int          stl [ND];
        bit          pst [ND];
        logic [15:0] prs [ND];
        logic        prc [ND];
        logic        pro [ND];
        bit          armed   = 0;
        bit          was_rst = 0;
        exp_t        e;
        for (int i = 0; i < ND; i++) begin
            stl[i] = 0;
            pst[i] = 0;
        end
        while (!done) begin
            @(negedge clk);
            if (done) break;
            n++;
            if (!rst_n) begin
                for (int i = 0; i < ND; i++) begin
                    q[i].delete();
                    pst[i] = 0;
                end
                armed   = 1;
                was_rst = 1;
                continue;
            end
            if (!armed) continue;
            for (int i = 0; i < ND; i++) begin
                if (was_rst) begin
                    chk(i, "rst_out_valid", ov_w[i], 0);
                    chk(i, "rst_s", s_w[i], 0);
                    chk(i, "rst_cout", co_w[i], 0);
                    chk(i, "rst_ovf", of_w[i], 0);
                    chk(i, "rst_in_ready", ir_w[i], 1);
                end
                if (pst[i]) begin
                    chk(i, "stall_valid", ov_w[i], 1);
                    chk(i, "stall_s", s_w[i], prs[i]);
                    chk(i, "stall_cout", co_w[i], prc[i]);
                    chk(i, "stall_ovf", of_w[i], pro[i]);
                end
                chk(i, "in_ready", ir_w[i], int'(!ov_w[i] || out_ready));
                if (ov_w[i] && out_ready) begin
                    if (q[i].size() == 0) begin
                        chk(i, "spurious_out", ov_w[i], 0);
                    end else begin
                        e = q[i].pop_front();
                        chk(i, "s", s_w[i], e.r.s);
                        chk(i, "cout", co_w[i], e.r.c);
                        chk(i, "ovf", of_w[i], e.r.o);
                        chk(i, "latency", n - e.n,
                            WD[i] / SG[i] + stl[i] - e.stl);
                    end
                end
                if (in_valid && ir_w[i]) begin
                    e.r   = model(WD[i], a_in, b_in, cin_in, sub_in);
                    e.n   = n;
                    e.stl = stl[i];
                    q[i].push_back(e);
                end
                pst[i] = ov_w[i] && !out_ready;
                if (pst[i]) stl[i]++;
                prs[i] = s_w[i];
                prc[i] = co_w[i];
                pro[i] = of_w[i];
            end
            was_rst = 0;
        end
    endtask

    task automatic set_rand();
        a_in   = 16'($urandom);
        b_in   = 16'($urandom);
        cin_in = 1'($urandom);
        sub_in = 1'($urandom);
    endtask

    // Hold one beat until the reference instance takes it.
    task automatic send(input logic [15:0] av, input logic [15:0] bv,
                        input logic ci, input logic sb);
        bit ok = 0;
        a_in     = av;
        b_in     = bv;
        cin_in   = ci;
        sub_in   = sb;
        in_valid = 1'b1;
        for (int c = 0; c < 50 && !ok; c++) begin
            @(negedge clk);
            ok = ir_w[0];
            @(posedge clk);
            #1;
        end
        chk(0, "accept", int'(ok), 1);
    endtask

    task automatic idle(input int cyc);
        in_valid = 1'b0;
        repeat (cyc) @(posedge clk);
        #1;
    endtask

    task automatic stimulus();
        int k;
        int cnt;
        bit acc;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a_in      = '0;
        b_in      = '0;
        cin_in    = 1'b0;
        sub_in    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        send(16'd255, 16'd1, 1'b0, 1'b0);
        send(16'd511, 16'd1, 1'b0, 1'b0);
        send(16'd511, 16'd0, 1'b1, 1'b0);
        send(16'd5,   16'd7, 1'b0, 1'b1);
        send(16'd256, 16'd1, 1'b0, 1'b1);
        idle(6);

        k   = 0;
        cnt = 0;
        set_rand();
        while (k < 8 && cnt < 100) begin
            out_ready = !(cnt >= 4 && cnt < 8);
            in_valid  = 1'b1;
            @(negedge clk);
            acc = ir_w[0];
            @(posedge clk);
            #1;
            if (acc) begin
                k++;
                set_rand();
            end
            cnt++;
        end
        chk(0, "stream_beats", k, 8);
        out_ready = 1'b1;
        idle(6);

        for (int c = 0; c < 400; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 3) != 0);
            set_rand();
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        idle(6);

        for (int c = 0; c < 3; c++) begin
            send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send(16'd100, 16'd23, 1'b1, 1'b0);
        in_valid = 1'b0;

        for (int c = 0; c < 60 && pending() > 0; c++) begin
            @(posedge clk);
            #1;
        end
        idle(4);
        chk(-1, "drain_pending", pending(), 0);
        done = 1;
    endtask

    initial begin
        pin("m_add_ovf", model(9, 16'd255, 16'd1, 1'b0, 1'b0), 1'b1, 1'b0, 256);
        pin("m_wrap",    model(9, 16'd511, 16'd1, 1'b0, 1'b0), 1'b0, 1'b1, 0);
        pin("m_wrap_ci", model(9, 16'd511, 16'd0, 1'b1, 1'b0), 1'b0, 1'b1, 0);
        pin("m_sub",     model(9, 16'd5,   16'd7, 1'b0, 1'b1), 1'b0, 1'b0, 510);
        pin("m_sub_ovf", model(9, 16'd256, 16'd1, 1'b0, 1'b1), 1'b1, 1'b1, 255);
        pin("m_w16",     model(16, 16'hFFFF, 16'h0001, 1'b1, 1'b0), 1'b0, 1'b1, 1);
        fork
            monitor();
            stimulus();
        join
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
